// File: rtl/part_ttl_pkg.sv
// Shared definitions for the dual 4-bit addressable latch.
//   IDX_W      : width of the shared bit index {S0,S1}
//   idx_t      : bit index type
//   mode_t     : per-channel operating mode, encoded as {E_N, CLR_N}
//   mode_of()  : maps the two active-low controls onto a mode
package part_ttl_pkg;

    localparam int IDX_W = 2;
    localparam int Q_W   = 1 << IDX_W;

    typedef logic [IDX_W-1:0] idx_t;

    // The encoding is the raw {E_N, CLR_N} pair, so decoding is a plain cast.
    typedef enum logic [1:0] {
        MODE_DEMUX  = 2'b00,
        MODE_LATCH  = 2'b01,
        MODE_CLEAR  = 2'b10,
        MODE_MEMORY = 2'b11
    } mode_t;

    function automatic mode_t mode_of(input logic e_n, input logic clr_n);
        return mode_t'({e_n, clr_n});
    endfunction

endpackage

// File: rtl/part_addr_latch_dual4_if.sv
// Pin bundle of the dual 4-bit addressable latch.
//   Da, Db          : channel data bits
//   S0, S1          : shared address, index = {S0,S1}
//   Ea_N, Eb_N      : active-low per-channel write enables
//   CLRa_N, CLRb_N  : active-low per-channel synchronous clears
//   Qa, Qb          : registered channel outputs
// master drives the controls and reads Q; slave is the latch itself.
interface part_addr_latch_dual4_if;

    logic       Da;
    logic       Db;
    logic       S0;
    logic       S1;
    logic       Ea_N;
    logic       Eb_N;
    logic       CLRa_N;
    logic       CLRb_N;
    logic [3:0] Qa;
    logic [3:0] Qb;

    modport master (
        output Da, Db, S0, S1, Ea_N, Eb_N, CLRa_N, CLRb_N,
        input  Qa, Qb
    );

    modport slave (
        input  Da, Db, S0, S1, Ea_N, Eb_N, CLRa_N, CLRb_N,
        output Qa, Qb
    );

endinterface

// File: rtl/part_addr_latch_chan.sv
// One channel of the addressable latch.
//   CLK, RESET : clock, asynchronous active-high reset to RESET_VALUE
//   D          : data bit
//   index      : addressed bit of Q
//   E_N, CLR_N : active-low write enable / synchronous clear
//   Q          : registered 4-bit output
module part_addr_latch_chan
    import part_ttl_pkg::*;
#(
    parameter logic [Q_W-1:0] RESET_VALUE = '0
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           D,
    input  idx_t           index,
    input  logic           E_N,
    input  logic           CLR_N,
    output logic [Q_W-1:0] Q
);

    logic [Q_W-1:0] sel;
    logic [Q_W-1:0] dmask;
    mode_t          mode;

    always_comb begin
        sel   = Q_W'(1) << index;
        dmask = sel & {Q_W{D}};
        mode  = mode_of(E_N, CLR_N);
    end

    // D and index only reach Q in the two writing modes, so unknowns on them
    // are harmless while the channel holds or clears.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Q <= RESET_VALUE;
        end else begin
            case (mode)
                MODE_LATCH:  Q <= (Q & ~sel) | dmask;
                MODE_DEMUX:  Q <= dmask;
                MODE_CLEAR:  Q <= '0;
                MODE_MEMORY: Q <= Q;
                default:     Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/part_addr_latch_dual4.sv
// Dual 4-bit addressable latch: two independent channels sharing one address.
//   CLK, RESET  : clock, asynchronous active-high reset
//   bus (slave) : per-channel data/enable/clear, shared S0/S1, outputs Qa/Qb
//   RESET_VALUE : value both outputs take while RESET is high
module part_addr_latch_dual4
    import part_ttl_pkg::*;
#(
    parameter logic [3:0] RESET_VALUE = 4'b0000
) (
    input  logic                     CLK,
    input  logic                     RESET,
    part_addr_latch_dual4_if.slave   bus
);

    idx_t index;

    // S0 is the MSB of the index.
    assign index = {bus.S0, bus.S1};

    part_addr_latch_chan #(
        .RESET_VALUE (RESET_VALUE)
    ) u_chan_a (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (bus.Da),
        .index (index),
        .E_N   (bus.Ea_N),
        .CLR_N (bus.CLRa_N),
        .Q     (bus.Qa)
    );

    part_addr_latch_chan #(
        .RESET_VALUE (RESET_VALUE)
    ) u_chan_b (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (bus.Db),
        .index (index),
        .E_N   (bus.Eb_N),
        .CLR_N (bus.CLRb_N),
        .Q     (bus.Qb)
    );

endmodule

// File: tb/tb_part_addr_latch_dual4.sv
// Scoreboard bench for part_addr_latch_dual4 with RESET_VALUE = 4'b1010.
module tb_part_addr_latch_dual4;

    // Mode encodings as {E_N, CLR_N}
    localparam logic [1:0] LA = 2'b01;  // addressable latch
    localparam logic [1:0] ME = 2'b11;  // memory
    localparam logic [1:0] DM = 2'b00;  // demux
    localparam logic [1:0] CL = 2'b10;  // clear

    typedef struct {
        logic [3:0] qa;
        logic [3:0] qb;
        string      name;
    } exp_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    part_addr_latch_dual4_if bus();

    part_addr_latch_dual4 #(
        .RESET_VALUE (4'b1010)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [3:0] ea, input logic [3:0] eb);
        checks++;
        if (bus.Qa !== ea || bus.Qb !== eb) begin
            failures++;
            $display("FAIL %s: Qa=%b Qb=%b expected Qa=%b Qb=%b", nm, bus.Qa, bus.Qb, ea, eb);
        end
    endtask

    // One stimulus cycle: drive at the falling edge, queue the result expected
    // after the following rising edge.
    task automatic step(input logic rst,
                        input logic [1:0] ma, input logic da,
                        input logic [1:0] mb, input logic db,
                        input logic [1:0] idx,
                        input logic [3:0] qa, input logic [3:0] qb,
                        input string nm);
        exp_t e;
        @(negedge CLK);
        RESET      = rst;
        bus.Ea_N   = ma[1];
        bus.CLRa_N = ma[0];
        bus.Eb_N   = mb[1];
        bus.CLRb_N = mb[0];
        bus.Da     = da;
        bus.Db     = db;
        bus.S0     = idx[1];
        bus.S1     = idx[0];
        e.qa   = qa;
        e.qb   = qb;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: every rising edge presents a new Q; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, e.qa, e.qb);
            end
        end
    end

    initial begin
        logic [3:0] walk [4];
        walk[0] = 4'b0001;
        walk[1] = 4'b0011;
        walk[2] = 4'b0111;
        walk[3] = 4'b1111;

        bus.Ea_N = 1'b1; bus.Eb_N = 1'b1;
        bus.CLRa_N = 1'b1; bus.CLRb_N = 1'b1;
        bus.Da = 1'b0; bus.Db = 1'b0; bus.S0 = 1'b0; bus.S1 = 1'b0;

        #1 RESET = 1'b1;
        #2 check("reset_init", 4'b1010, 4'b1010);

        step(0, ME, 0, ME, 0, 2'd0, 4'b1010, 4'b1010, "mem_after_rst");
        step(0, LA, 0, CL, 0, 2'd1, 4'b1000, 4'b0000, "pre_pulse");

        // Reset pulse entirely between two edges.
        @(negedge CLK);
        bus.Ea_N = 1'b1; bus.CLRa_N = 1'b1;
        bus.Eb_N = 1'b1; bus.CLRb_N = 1'b1;
        #1 RESET = 1'b1;
        #1 check("rst_pulse", 4'b1010, 4'b1010);
        #1 RESET = 1'b0;
        step(0, ME, 1, ME, 1, 2'd3, 4'b1010, 4'b1010, "post_pulse");

        // Reset held across writes.
        step(1, LA, 1, DM, 1, 2'd0, 4'b1010, 4'b1010, "rst_hold0");
        step(1, LA, 0, DM, 1, 2'd1, 4'b1010, 4'b1010, "rst_hold1");
        step(1, LA, 1, LA, 0, 2'd3, 4'b1010, 4'b1010, "rst_hold2");
        step(0, CL, 1, CL, 1, 2'd2, 4'b0000, 4'b0000, "clr_both");

        for (int i = 0; i < 4; i++)
            step(0, LA, 1, ME, 1, 2'(i), walk[i], 4'b0000, $sformatf("walk_a%0d", i));
        for (int i = 0; i < 4; i++)
            step(0, ME, 0, LA, 1, 2'(i), 4'b1111, walk[i], $sformatf("walk_b%0d", i));

        step(0, ME, 0, DM, 1, 2'd2, 4'b1111, 4'b0100, "demux_d1");
        step(0, ME, 1, DM, 0, 2'd2, 4'b1111, 4'b0000, "demux_d0");

        step(0, LA, 0, ME, 0, 2'd2, 4'b1011, 4'b0000, "set_1011");
        for (int i = 0; i < 5; i++)
            step(0, ME, i[0], ME, ~i[0], 2'(i), 4'b1011, 4'b0000, $sformatf("memory%0d", i));
        step(0, CL, 1, ME, 1, 2'd3, 4'b0000, 4'b0000, "clear_a");

        step(0, LA, 1, LA, 1, 2'd1, 4'b0010, 4'b0010, "indep_pre");
        step(0, LA, 1, CL, 1, 2'd3, 4'b1010, 4'b0000, "indep");

        step(0, LA, 1, ME, 0, 2'd0, 4'b1011, 4'b0000, "rewrite1");
        step(0, LA, 0, ME, 0, 2'd0, 4'b1010, 4'b0000, "rewrite0");
        step(0, LA, 1, ME, 0, 2'd0, 4'b1011, 4'b0000, "rewrite1b");

        step(0, CL, 1, DM, 1, 2'd0, 4'b0000, 4'b0001, "mixed_modes");

        // Reset raised 1 ns before an edge that carries a latch write.
        step(0, LA, 1, ME, 0, 2'd0, 4'b1010, 4'b1010, "rst_mid_op");
        #4 RESET = 1'b1;
        step(0, LA, 1, ME, 0, 2'd0, 4'b1011, 4'b1010, "after_rst_write");

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(posedge CLK);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
